// File: rtl/step_button_ctrl.sv
// step_button_ctrl: turns the two raw address-step buttons into clean one-cycle
// addr_up / addr_dn pulses (synchronize, debounce, edge pulse, hold-to-repeat)
// and adds a timed auto-step on addr_dn while auto_en is high.

// Per-button lane: 2-FF sync, debounce, IDLE/DELAY/REPEAT pulse FSM.
// pulse_o is combinational; the top registers it together with the merge.
module step_btn_lane #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic conflict_i,
  output logic db_o,
  output logic pulse_o
);
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s;
  logic             db_q, db_d, db_prev_q;
  logic [CNT_W-1:0] dc_q, dc_d, hc_q, hc_d;
  logic             rise;
  state_e           state_q, state_d;

  assign s    = sync_q[1];
  assign rise = db_q & ~db_prev_q;
  assign db_o = db_q;

  // Two-flop synchronizer on the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw_i};
  end

  // Debounce: flip db only after s has disagreed for DEBOUNCE_CYC straight cycles.
  always_comb begin
    db_d = db_q;
    dc_d = dc_q + ONE;
    if (s == db_q) begin
      dc_d = '0;
    end else if (dc_q == DB_LAST) begin
      db_d = s;
      dc_d = '0;
    end
  end

  // Debounce state and the previous level used for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dc_q      <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      dc_q      <= dc_d;
    end
  end

  // Pulse FSM: first pulse on a fresh rise, then delay, then periodic repeat.
  // Both buttons held pins the FSM in IDLE, so only a later fresh rise can step.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    pulse_o = 1'b0;
    if (conflict_i) begin
      state_d = S_IDLE;
      hc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            pulse_o = 1'b1;
            hc_d    = '0;
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (!db_q) begin
            state_d = S_IDLE;
            hc_d    = '0;
          end else if (hc_q == RD_LAST) begin
            pulse_o = 1'b1;
            hc_d    = '0;
            state_d = S_REPEAT;
          end else begin
            hc_d = hc_q + ONE;
          end
        end
        S_REPEAT: begin
          if (!db_q) begin
            state_d = S_IDLE;
            hc_d    = '0;
          end else if (hc_q == RP_LAST) begin
            pulse_o = 1'b1;
            hc_d    = '0;
          end else begin
            hc_d = hc_q + ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          hc_d    = '0;
        end
      endcase
    end
  end

  // FSM state and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
    end
  end
endmodule

module step_button_ctrl #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned AUTO_PERIOD   = 100_000_000
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_dn_raw,
  input  logic       auto_en,
  output logic       addr_up,
  output logic       addr_dn,
  output logic [1:0] btn_state
);
  localparam int unsigned      NUM_BTN = 2;   // lane 0 = up, lane 1 = dn
  localparam logic [CNT_W-1:0] AP_LAST = CNT_W'(AUTO_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NUM_BTN-1:0] raw, db, pulse;
  logic               conflict;
  logic [CNT_W-1:0]   ac_q, ac_d;
  logic               auto_pulse;
  logic               addr_up_q, addr_dn_q;

  assign raw      = {btn_dn_raw, btn_up_raw};
  assign conflict = &db;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    step_btn_lane #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .clk       (clk),
      .rst_n     (Rst_n),
      .raw_i     (raw[g]),
      .conflict_i(conflict),
      .db_o      (db[g]),
      .pulse_o   (pulse[g])
    );
  end

  // Auto-step timer: runs only while enabled, restarts from zero on re-enable.
  always_comb begin
    ac_d       = ac_q + ONE;
    auto_pulse = 1'b0;
    if (!auto_en) begin
      ac_d = '0;
    end else if (ac_q == AP_LAST) begin
      auto_pulse = 1'b1;
      ac_d       = '0;
    end
  end

  // Auto-step counter register.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) ac_q <= '0;
    else        ac_q <= ac_d;
  end

  // Output merge: up wins over any dn/auto pulse; dn and auto coalesce.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_up_q <= 1'b0;
      addr_dn_q <= 1'b0;
    end else begin
      addr_up_q <= pulse[0];
      addr_dn_q <= (pulse[1] | auto_pulse) & ~pulse[0];
    end
  end

  assign addr_up   = addr_up_q;
  assign addr_dn   = addr_dn_q;
  assign btn_state = db;
endmodule

// File: tb/tb_step_button_ctrl.sv
// Bench for step_button_ctrl with small timing constants. A cycle-level
// behavioural model (press age arithmetic, enabled-cycle counting) checks
// every output after every clock; tables and directed sequences add
// hand-derived pulse counts and times.
module tb_step_button_ctrl;
  localparam int DB = 4, RD = 10, RP = 3, AP = 8;

  logic       clk = 1'b0, Rst_n = 1'b1;
  logic       btn_up_raw = 1'b0, btn_dn_raw = 1'b0, auto_en = 1'b0;
  logic       addr_up, addr_dn;
  logic [1:0] btn_state;

  step_button_ctrl #(
    .CNT_W(32), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .AUTO_PERIOD(AP)
  ) dut (
    .clk(clk), .Rst_n(Rst_n), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
    .auto_en(auto_en), .addr_up(addr_up), .addr_dn(addr_dn), .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc, n_up, n_dn, f_up, f_dn, last_dn;
  int pt_dn[$];

  // model state: index 0 = up, 1 = dn
  int m_s1[2], m_s[2], m_db[2], m_dbp[2], m_run[2], m_age[2], m_en_cnt;
  int e_up, e_dn;

  typedef struct {
    logic up, dn, au;
    int   cycles, exp_up, exp_dn;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_run[b] = 0; m_age[b] = -1;
    end
    m_en_cnt = 0; e_up = 0; e_dn = 0;
  endtask

  // One clock of the behavioural model, using the inputs present at the edge.
  task automatic model_clock();
    int p[2];
    int ap;
    int raw[2];
    raw[0] = int'(btn_up_raw); raw[1] = int'(btn_dn_raw);
    // pulse decision from the pre-edge debounced levels
    for (int b = 0; b < 2; b++) begin
      if (m_db[0] == 1 && m_db[1] == 1) begin
        p[b] = 0; m_age[b] = -1;
      end else if (m_age[b] < 0) begin
        p[b] = (m_db[b] == 1 && m_dbp[b] == 0) ? 1 : 0;
        if (p[b] == 1) m_age[b] = 1;
      end else if (m_db[b] == 0) begin
        p[b] = 0; m_age[b] = -1;
      end else begin
        p[b] = (m_age[b] == RD || (m_age[b] > RD && (m_age[b] - RD) % RP == 0)) ? 1 : 0;
        m_age[b]++;
      end
    end
    // debounce on run length of disagreement, then the sync pipeline
    for (int b = 0; b < 2; b++) begin
      m_dbp[b] = m_db[b];
      m_run[b] = (m_s[b] != m_db[b]) ? m_run[b] + 1 : 0;
      if (m_run[b] == DB) begin m_db[b] = m_s[b]; m_run[b] = 0; end
      m_s[b]  = m_s1[b];
      m_s1[b] = raw[b];
    end
    if (auto_en !== 1'b1) begin
      m_en_cnt = 0; ap = 0;
    end else begin
      ap = (m_en_cnt % AP == AP - 1) ? 1 : 0;
      m_en_cnt++;
    end
    e_up = p[0];
    e_dn = ((p[1] == 1 || ap == 1) && p[0] == 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (Rst_n) model_clock();
    #1;
    cyc++;
    chk("addr_up", addr_up, e_up);
    chk("addr_dn", addr_dn, e_dn);
    chk("btn_state", btn_state, m_db[1] * 2 + m_db[0]);
    if (addr_up === 1'b1) begin n_up++; if (f_up < 0) f_up = cyc; end
    if (addr_dn === 1'b1) begin
      n_dn++; if (f_dn < 0) f_dn = cyc; last_dn = cyc; pt_dn.push_back(cyc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic mark();
    cyc = 0; n_up = 0; n_dn = 0; f_up = -1; f_dn = -1; last_dn = -1; pt_dn.delete();
  endtask

  task automatic settle();
    btn_up_raw = 1'b0; btn_dn_raw = 1'b0; auto_en = 1'b0;
    run(20);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 10, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 12, 1, 0};  // press up
    vecs[2] = '{1'b0, 1'b0, 1'b0, 12, 1, 0};  // release: repeat lands before db falls
    vecs[3] = '{1'b0, 1'b1, 1'b0, 12, 0, 1};  // press dn
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16, 0, 5};  // repeat + auto, one coincident
    vecs[5] = '{1'b0, 1'b0, 1'b0, 12, 0, 2};  // release dn, tail repeats
    vecs[6] = '{1'b1, 1'b1, 1'b0, 15, 0, 0};  // both together: conflict
    vecs[7] = '{1'b1, 1'b0, 1'b0, 12, 0, 0};  // dn released, up has no fresh rise
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16, 0, 2};  // auto only

    model_reset(); mark();
    #1 Rst_n = 1'b0;

    // 1: reset with up held and auto on
    btn_up_raw = 1'b1; auto_en = 1'b1;
    run(4);
    chk("t1_rst_up", addr_up, 0);
    chk("t1_rst_dn", addr_dn, 0);
    Rst_n = 1'b1; mark();
    run(8);
    chk("t1_first_up", f_up, 7);
    chk("t1_first_auto", f_dn, 8);
    settle();

    // 2: bounce then settle high
    mark();
    for (int i = 0; i < 10; i++) begin btn_up_raw = (i % 2 == 0); run(2); end
    chk("t2_bounce_quiet", n_up, 0);
    btn_up_raw = 1'b1; mark(); run(12);
    chk("t2_settle_time", f_up, 7);
    chk("t2_settle_count", n_up, 1);
    settle();

    // 3: hold dn
    mark(); btn_dn_raw = 1'b1; run(47);
    chk("t3_t0", f_dn, 7);
    chk("t3_count", n_dn, 12);
    chk("t3_rep1", pt_dn.size() > 1 ? pt_dn[1] : -1, 17);
    chk("t3_rep2", pt_dn.size() > 2 ? pt_dn[2] : -1, 20);
    chk("t3_rep3", pt_dn.size() > 3 ? pt_dn[3] : -1, 23);
    btn_dn_raw = 1'b0; run(20);
    chk("t3_last", last_dn, 53);
    chk("t3_total", n_dn, 14);
    settle();

    // 4: auto-step
    mark(); auto_en = 1'b1; run(24);
    chk("t4_count", n_dn, 3);
    chk("t4_first", f_dn, 8);
    chk("t4_last", last_dn, 24);
    auto_en = 1'b0; run(3);
    mark(); auto_en = 1'b1; run(10);
    chk("t4_reenable", f_dn, 8);
    chk("t4_reenable_n", n_dn, 1);
    settle();

    // 5: conflict
    mark(); btn_up_raw = 1'b1; btn_dn_raw = 1'b1; run(30);
    chk("t5_both_up", n_up, 0);
    chk("t5_both_dn", n_dn, 0);
    chk("t5_state", btn_state, 3);
    btn_up_raw = 1'b0; run(12);
    chk("t5_rel_up", n_up, 0);
    chk("t5_rel_dn", n_dn, 0);
    btn_dn_raw = 1'b0; run(12);
    btn_up_raw = 1'b1; mark(); run(8);
    chk("t5_repress_t", f_up, 7);
    chk("t5_repress_n", n_up, 1);
    settle();
    mark(); auto_en = 1'b1; run(1); btn_up_raw = 1'b1; run(7);
    chk("t5_coinc_up", addr_up, 1);
    chk("t5_coinc_dn", addr_dn, 0);
    chk("t5_coinc_ndn", n_dn, 0);
    settle();
    mark(); auto_en = 1'b1; run(1); btn_dn_raw = 1'b1; run(7);
    chk("t5_merge_dn", addr_dn, 1);
    chk("t5_merge_n", n_dn, 1);
    settle();

    // 6: async reset mid-REPEAT
    mark(); btn_dn_raw = 1'b1; run(23);
    chk("t6_pre", addr_dn, 1);
    #2 Rst_n = 1'b0;
    #1 model_reset();
    chk("t6_async_dn", addr_dn, 0);
    chk("t6_async_state", btn_state, 0);
    run(3);
    Rst_n = 1'b1; mark(); run(8);
    chk("t6_fresh_rise", f_dn, 7);
    settle();

    // table-driven segments from a fresh reset
    Rst_n = 1'b0; model_reset(); run(2); Rst_n = 1'b1;
    for (int v = 0; v < 9; v++) begin
      btn_up_raw = vecs[v].up; btn_dn_raw = vecs[v].dn; auto_en = vecs[v].au;
      mark(); run(vecs[v].cycles);
      chk($sformatf("vec%0d_up", v), n_up, vecs[v].exp_up);
      chk($sformatf("vec%0d_dn", v), n_dn, vecs[v].exp_dn);
    end
    settle();

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) btn_up_raw = ~btn_up_raw;
      if ($urandom_range(19) == 0) btn_dn_raw = ~btn_dn_raw;
      if ($urandom_range(39) == 0) auto_en = ~auto_en;
      if ($urandom_range(399) == 0) begin
        Rst_n = 1'b0;
        #1 model_reset();
        chk("rnd_async_up", addr_up, 0);
        chk("rnd_async_dn", addr_dn, 0);
        tick();
        Rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
